hex_keypad_scanner: RTL and testbench

Scans a 4x4 hexadecimal keypad matrix, debounces it, and presents the pressed key as a 16-bit one-hot vector. It sits directly upstream of the hexadecimal-to-binary encoder, whose 16-line input it drives. It guarantees that the encoder only ever sees all-zero or exactly-one-hot input. Multi-key presses are flagged and never forwarded.

---
 rtl/hex_keypad_scanner.sv | 108 ++++++++++
 tb/tb_hex_keypad_scanner.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: scans a 4x4 keypad, debounces whole-matrix snapshots and
// presents a single held key as a one-hot vector; multi-key presses are flagged.
module hex_keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] key_onehot,
    output logic        key_valid,
    output logic        key_press,
    output logic        multi_key
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, PRESSED, MULTI} state_t;

    state_t      state, state_nx;
    logic [DW-1:0] div;
    logic [1:0]  col;
    logic [15:0] snapshot, last_snap, snap, onehot_nx;
    logic [CW-1:0] stable_cnt, cnt_nx;
    logic        sample, scan_done, qualified, single, valid_nx, press_nx, multi_nx;

    assign sample    = div == DIV_LAST;
    assign scan_done = sample && col == 2'd3;
    assign single    = snap != 16'd0 && (snap & (snap - 16'd1)) == 16'd0;
    assign cnt_nx    = snap == last_snap ? (stable_cnt == CNT_MAX ? CNT_MAX : stable_cnt + 1'b1) : CW'(1);
    // the count only reaches its maximum after DEBOUNCE_SCANS identical scans
    assign qualified = scan_done && cnt_nx == CNT_MAX;

    always_comb begin
        snap = snapshot;
        for (int r = 0; r < 4; r++) snap[4 * r + int'(col)] = row_in[r];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div        <= '0;
            col        <= 2'd0;
            col_out    <= 4'b0001;
            snapshot   <= '0;
            last_snap  <= '0;
            stable_cnt <= '0;
        end else begin
            div <= sample ? '0 : div + 1'b1;
            if (sample) begin
                col      <= col + 2'd1;
                col_out  <= {col_out[2:0], col_out[3]};
                snapshot <= snap;
            end
            if (scan_done) begin
                stable_cnt <= cnt_nx;
                last_snap  <= snap;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        onehot_nx = key_onehot;
        valid_nx  = key_valid;
        multi_nx  = multi_key;
        press_nx  = 1'b0;
        if (qualified) begin
            if (snap == 16'd0) begin
                state_nx  = IDLE;
                onehot_nx = '0;
                valid_nx  = 1'b0;
                multi_nx  = 1'b0;
            end else if (single) begin
                if (state != PRESSED || snap != key_onehot) begin
                    state_nx  = PRESSED;
                    onehot_nx = snap;
                    valid_nx  = 1'b1;
                    multi_nx  = 1'b0;
                    press_nx  = 1'b1;
                end
            end else begin
                state_nx  = MULTI;
                onehot_nx = '0;
                valid_nx  = 1'b0;
                multi_nx  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            key_onehot <= '0;
            key_valid  <= 1'b0;
            key_press  <= 1'b0;
            multi_key  <= 1'b0;
        end else begin
            state      <= state_nx;
            key_onehot <= onehot_nx;
            key_valid  <= valid_nx;
            key_press  <= press_nx;
            multi_key  <= multi_nx;
        end
    end
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner: directed keypad scenarios; expected output events are
// queued by the stimulus and matched by a monitor on every output change.
module tb_hex_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] key_onehot;
    logic        key_valid, key_press, multi_key;
    logic [15:0] keys;
    logic [18:0] sb[$];
    logic [17:0] prev = '0;
    int          vectors = 0;
    int          errors  = 0;

    hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
        .key_onehot(key_onehot), .key_valid(key_valid), .key_press(key_press), .multi_key(multi_key)
    );

    always #5 clk = ~clk;

    // keypad matrix: a pressed key connects its row to its driven column
    always_comb begin
        for (int r = 0; r < 4; r++) row_in[r] = |(keys[4 * r +: 4] & col_out);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input logic [15:0] oh, input logic v, input logic m, input logic p);
        sb.push_back({oh, v, m, p});
    endtask

    task automatic wait_scans(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    // stop at the first cycle of column 0 of a fresh scan
    task automatic align();
        int n;
        n = 0;
        @(negedge clk);
        while (col_out != 4'b1000 && n < 64) begin @(negedge clk); n++; end
        while (col_out != 4'b0001 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) chk("align_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        keys  = '0;
        fork
            forever begin
                @(negedge clk);
                chk("invariant", {30'd0, key_valid != (key_onehot != 0),
                                  (key_onehot & (key_onehot - 16'd1)) != 0}, 32'd0);
                if ({key_onehot, key_valid, multi_key} != prev || key_press) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_event", {13'd0, key_onehot, key_valid, multi_key, key_press}, 32'h7ffff);
                    end else begin
                        chk("event", {13'd0, key_onehot, key_valid, multi_key, key_press}, {13'd0, sb.pop_front()});
                    end
                    prev = {key_onehot, key_valid, multi_key};
                end
            end
        join_none

        // 1: reset state and column rotation
        repeat (3) @(negedge clk);
        chk("rst_col", {28'd0, col_out}, 32'h1);
        chk("rst_outputs", {13'd0, key_onehot, key_valid, multi_key, key_press}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("col_rotate", {28'd0, col_out}, 32'(1 << (i % 4)));
            repeat (4) @(negedge clk);
        end
        chk("idle_outputs", {13'd0, key_onehot, key_valid, multi_key, key_press}, 32'd0);

        // 2: clean key 9, held without repeat pulses, then released
        align(); keys = 16'h0200; expect_ev(16'h0200, 1'b1, 1'b0, 1'b1);
        wait_scans(6);
        align(); keys = 16'h0000; expect_ev(16'h0000, 1'b0, 1'b0, 1'b0);
        wait_scans(4);

        // 3: key 9 bouncing; only three clean scans after the bounce qualify
        align(); keys = 16'h0200;
        wait_scans(1); keys = 16'h0000;
        wait_scans(1); keys = 16'h0200; expect_ev(16'h0200, 1'b1, 1'b0, 1'b1);
        wait_scans(2);
        chk("bounce_not_early", {31'd0, key_valid}, 32'd0);
        wait_scans(4);
        align(); keys = 16'h0000; expect_ev(16'h0000, 1'b0, 1'b0, 1'b0);
        wait_scans(4);

        // 4: keys 0 and 15 together, then release key 15
        align(); keys = 16'h8001; expect_ev(16'h0000, 1'b0, 1'b1, 1'b0);
        wait_scans(4);
        chk("multi_flag", {29'd0, multi_key, key_valid, key_press}, 32'h4);
        align(); keys = 16'h0001; expect_ev(16'h0001, 1'b1, 1'b0, 1'b1);
        wait_scans(4);
        align(); keys = 16'h0000; expect_ev(16'h0000, 1'b0, 1'b0, 1'b0);
        wait_scans(4);

        // 5: key 5 switched directly to key 10, then release all
        align(); keys = 16'h0020; expect_ev(16'h0020, 1'b1, 1'b0, 1'b1);
        wait_scans(4);
        align(); keys = 16'h0400; expect_ev(16'h0400, 1'b1, 1'b0, 1'b1);
        wait_scans(4);
        align(); keys = 16'h0000; expect_ev(16'h0000, 1'b0, 1'b0, 1'b0);
        wait_scans(4);

        // 6: key 3 valid, reset mid-column, revalidation after three scans
        align(); keys = 16'h0008; expect_ev(16'h0008, 1'b1, 1'b0, 1'b1);
        wait_scans(4);
        chk("key3_valid", {15'd0, key_onehot, key_valid}, {15'd0, 16'h0008, 1'b1});
        repeat (2) @(negedge clk);
        expect_ev(16'h0000, 1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {13'd0, key_onehot, key_valid, multi_key, key_press}, 32'd0);
        chk("async_rst_col", {28'd0, col_out}, 32'h1);
        repeat (2) @(negedge clk);
        expect_ev(16'h0008, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
        repeat (47) @(negedge clk);
        chk("revalidate_not_early", {31'd0, key_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("revalidate", {15'd0, key_onehot, key_valid}, {15'd0, 16'h0008, 1'b1});
        wait_scans(2);

        while (sb.size() > 0) begin
            vectors++;
            errors++;
            $display("FAIL missing_event: got none expected %h", sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
